slt_seq: RTL and testbench

- Multi-cycle signed less-than unit: latches two N-bit two's-complement operands and computes a<b, a==b and a-b by sequencing one W-bit adder_n slice over N/W cycles, LSB slice first.
- Used where area is tight, e.g. a shared compare resource in the ALU/branch path.
- Valid/ready handshake on both sides.
- Signed-compare rule: operand signs differ -> result is a's sign bit; signs equal -> result is the MSB of the difference. No overflow handling needed.

---
 rtl/slt_seq.sv | 110 +++++++++++
 tb/tb_slt_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slt_seq.sv
// Multi-cycle signed compare/subtract unit: one W-bit adder slice is reused over
// N/W cycles (LSB slice first) to produce a-b, a<b (signed) and a==b.

module adder_n #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
endmodule

module slt_seq #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         lt,
    output logic         eq,
    output logic [N-1:0] diff
);
    localparam int S  = N / W;
    localparam int KW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          carry;
    logic          zero;
    logic [KW-1:0] k;
    logic [W-1:0]  a_sl;
    logic [W-1:0]  b_sl;
    logic [W-1:0]  sum;
    logic          cout;
    logic          last;

    assign a_sl    = a_q[int'(k)*W +: W];
    assign b_sl    = b_q[int'(k)*W +: W];
    assign last    = (k == KW'(S - 1));
    assign i_ready = (state == IDLE);

    // Subtraction as a + ~b + 1: the +1 enters as the initial carry of slice 0.
    adder_n #(.W(W)) u_add (
        .x    (a_sl),
        .y    (~b_sl),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            k       <= '0;
            o_valid <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
            diff    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= 1'b1;
                        zero  <= 1'b1;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    diff[int'(k)*W +: W] <= sum;
                    carry <= cout;
                    zero  <= zero & (sum == '0);
                    k     <= k + 1'b1;
                    // Differing signs decide the order outright; otherwise the difference cannot overflow.
                    if (last) begin
                        lt      <= (a_q[N-1] != b_q[N-1]) ? a_q[N-1] : sum[W-1];
                        eq      <= zero & (sum == '0);
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slt_seq.sv
// Directed and randomized checks of slt_seq at N/W = 32/8, 8/8 and 16/4.

module tb_slt_seq;
    logic clk = 1'b0;
    logic rst;

    logic        iv0, ir0, ov0, or0, lt0, eq0;
    logic [31:0] a0, b0, d0;
    logic        iv1, ir1, ov1, or1, lt1, eq1;
    logic [7:0]  a1, b1, d1;
    logic        iv2, ir2, ov2, or2, lt2, eq2;
    logic [15:0] a2, b2, d2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    slt_seq #(.N(32), .W(8)) dut0 (
        .clk(clk), .rst(rst), .i_valid(iv0), .i_ready(ir0), .a(a0), .b(b0),
        .o_valid(ov0), .o_ready(or0), .lt(lt0), .eq(eq0), .diff(d0)
    );
    slt_seq #(.N(8), .W(8)) dut1 (
        .clk(clk), .rst(rst), .i_valid(iv1), .i_ready(ir1), .a(a1), .b(b1),
        .o_valid(ov1), .o_ready(or1), .lt(lt1), .eq(eq1), .diff(d1)
    );
    slt_seq #(.N(16), .W(4)) dut2 (
        .clk(clk), .rst(rst), .i_valid(iv2), .i_ready(ir2), .a(a2), .b(b2),
        .o_valid(ov2), .o_ready(or2), .lt(lt2), .eq(eq2), .diff(d2)
    );

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic        elt;
        logic        eeq;
        logic [31:0] ediff;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setInputs(input int w, input logic [31:0] av, input logic [31:0] bv, input logic v);
        case (w)
            0: begin a0 = av; b0 = bv; iv0 = v; end
            1: begin a1 = av[7:0]; b1 = bv[7:0]; iv1 = v; end
            default: begin a2 = av[15:0]; b2 = bv[15:0]; iv2 = v; end
        endcase
    endtask

    task automatic setReady(input int w, input logic r);
        case (w)
            0: or0 = r;
            1: or1 = r;
            default: or2 = r;
        endcase
    endtask

    task automatic sample(input int w, output logic ir, output logic ov, output logic ltv,
                          output logic eqv, output logic [31:0] dv);
        case (w)
            0: begin ir = ir0; ov = ov0; ltv = lt0; eqv = eq0; dv = d0; end
            1: begin ir = ir1; ov = ov1; ltv = lt1; eqv = eq1; dv = {24'b0, d1}; end
            default: begin ir = ir2; ov = ov2; ltv = lt2; eqv = eq2; dv = {16'b0, d2}; end
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: signed compare at the instance width, independent of slicing.
    task automatic runModel(input int w, input logic [31:0] av, input logic [31:0] bv,
                            output logic elt, output logic eeq, output logic [31:0] ediff);
        case (w)
            0: begin
                elt = $signed(av) < $signed(bv);
                eeq = (av == bv);
                ediff = av - bv;
            end
            1: begin
                elt = $signed(av[7:0]) < $signed(bv[7:0]);
                eeq = (av[7:0] == bv[7:0]);
                ediff = {24'b0, av[7:0] - bv[7:0]};
            end
            default: begin
                elt = $signed(av[15:0]) < $signed(bv[15:0]);
                eeq = (av[15:0] == bv[15:0]);
                ediff = {16'b0, av[15:0] - bv[15:0]};
            end
        endcase
    endtask

    task automatic applyStimulus(input int w, input logic [31:0] av, input logic [31:0] bv, output int cyc);
        logic ir, ov, ltv, eqv;
        logic [31:0] dv;
        sample(w, ir, ov, ltv, eqv, dv);
        checkOutput($sformatf("i_ready before accept w%0d", w), ir, 1);
        setInputs(w, av, bv, 1'b1);
        tick;
        setInputs(w, av, bv, 1'b0);
        cyc = 0;
        sample(w, ir, ov, ltv, eqv, dv);
        while (!ov && cyc < 40) begin
            tick;
            cyc++;
            sample(w, ir, ov, ltv, eqv, dv);
        end
    endtask

    task automatic releaseResult(input int w);
        logic ir, ov, ltv, eqv;
        logic [31:0] dv;
        setReady(w, 1'b1);
        tick;
        setReady(w, 1'b0);
        sample(w, ir, ov, ltv, eqv, dv);
        checkOutput($sformatf("o_valid after o_ready w%0d", w), ov, 0);
        checkOutput($sformatf("i_ready after o_ready w%0d", w), ir, 1);
    endtask

    task automatic runAndCheck(input string tag, input int w, input logic [31:0] av, input logic [31:0] bv,
                               input logic elt, input logic eeq, input logic [31:0] ediff, input int lat);
        int cyc;
        logic ir, ov, ltv, eqv;
        logic [31:0] dv;
        applyStimulus(w, av, bv, cyc);
        checkOutput({tag, " latency"}, cyc, lat);
        sample(w, ir, ov, ltv, eqv, dv);
        checkOutput({tag, " lt"}, ltv, elt);
        checkOutput({tag, " eq"}, eqv, eeq);
        checkOutput({tag, " diff"}, dv, ediff);
        releaseResult(w);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic ir, ov, ltv, eqv, flag;
        logic [31:0] dv, ra, rb;
        logic elt, eeq;
        logic [31:0] ediff;
        int cyc;
        int lats[3] = '{4, 1, 4};

        vecs[0] = '{0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'hFFFF_FFFF, 4};
        vecs[1] = '{0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 4};
        vecs[2] = '{0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h0000_0001, 4};
        vecs[3] = '{0, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 4};
        vecs[4] = '{0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0000, 4};
        vecs[5] = '{0, 32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0100, 4};
        vecs[6] = '{1, 32'h0000_0080, 32'h0000_007F, 1'b1, 1'b0, 32'h0000_0001, 1};
        vecs[7] = '{1, 32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0000, 1};
        vecs[8] = '{2, 32'h0000_8000, 32'h0000_7FFF, 1'b1, 1'b0, 32'h0000_0001, 4};
        vecs[9] = '{2, 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_0000, 4};

        rst = 1'b1;
        for (int w = 0; w < 3; w++) begin
            setInputs(w, 32'h0, 32'h0, 1'b0);
            setReady(w, 1'b0);
        end
        #12;
        sample(0, ir, ov, ltv, eqv, dv);
        checkOutput("reset o_valid", ov, 0);
        checkOutput("reset lt", ltv, 0);
        checkOutput("reset eq", eqv, 0);
        checkOutput("reset diff", dv, 0);
        checkOutput("reset i_ready", ir, 1);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 10; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].b,
                        vecs[i].elt, vecs[i].eeq, vecs[i].ediff, vecs[i].lat);
        end

        // Backpressure with input churn during RUN and DONE.
        setInputs(0, 32'h1234_5678, 32'h8765_4321, 1'b1);
        tick;
        cyc = 0;
        sample(0, ir, ov, ltv, eqv, dv);
        while (!ov && cyc < 40) begin
            setInputs(0, $urandom, $urandom, 1'b1);
            tick;
            cyc++;
            sample(0, ir, ov, ltv, eqv, dv);
        end
        checkOutput("bp latency", cyc, 4);
        for (int h = 0; h < 3; h++) begin
            sample(0, ir, ov, ltv, eqv, dv);
            checkOutput($sformatf("bp hold%0d o_valid", h), ov, 1);
            checkOutput($sformatf("bp hold%0d i_ready", h), ir, 0);
            checkOutput($sformatf("bp hold%0d lt", h), ltv, 0);
            checkOutput($sformatf("bp hold%0d eq", h), eqv, 0);
            checkOutput($sformatf("bp hold%0d diff", h), dv, 32'h8ACF_1357);
            setInputs(0, $urandom, $urandom, 1'b1);
            tick;
        end
        setInputs(0, 32'h0, 32'h0, 1'b0);
        releaseResult(0);

        // Reset in the middle of RUN, after slice 1.
        setInputs(0, 32'h0000_0001, 32'h0000_0002, 1'b1);
        tick;
        setInputs(0, 32'h0, 32'h0, 1'b0);
        tick;
        tick;
        rst = 1'b1;
        #1;
        sample(0, ir, ov, ltv, eqv, dv);
        checkOutput("mid-run reset o_valid", ov, 0);
        checkOutput("mid-run reset i_ready", ir, 1);
        #3;
        rst = 1'b0;
        flag = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (ov0) flag = 1'b1;
        end
        checkOutput("no spurious o_valid", flag, 0);
        runAndCheck("after reset", 0, 32'hFFFF_FFFD, 32'h0000_0002, 1'b1, 1'b0, 32'hFFFF_FFFB, 4);

        // Randomized sweep against the signed reference.
        for (int w = 0; w < 3; w++) begin
            for (int n = 0; n < ((w == 1) ? 200 : 1000); n++) begin
                ra = $urandom;
                rb = ((n % 8) == 0) ? ra : $urandom;
                if ((n % 16) == 3) rb = ra ^ (32'h1 << $urandom_range(31, 0));
                runModel(w, ra, rb, elt, eeq, ediff);
                applyStimulus(w, ra, rb, cyc);
                sample(w, ir, ov, ltv, eqv, dv);
                if (cyc != lats[w] || ltv !== elt || eqv !== eeq || dv !== ediff) begin
                    checkOutput($sformatf("rand w%0d n%0d latency a=%h b=%h", w, n, ra, rb), cyc, lats[w]);
                    checkOutput($sformatf("rand w%0d n%0d lt", w, n), ltv, elt);
                    checkOutput($sformatf("rand w%0d n%0d eq", w, n), eqv, eeq);
                    checkOutput($sformatf("rand w%0d n%0d diff", w, n), dv, ediff);
                end else begin
                    total++;
                end
                releaseResult(w);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
